// File: rtl/deb_pkg.sv
// deb_pkg: shared constants and types for the deb_multi debouncer slice.
package deb_pkg;
   localparam int GLITCH_W = 8;
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;
   localparam int CNT_W_DEF = 4;
   typedef logic [GLITCH_W-1:0] glitch_t;
endpackage

// File: rtl/deb_multi_if.sv
// deb_multi_if: pad-side and debounced-side bundle of deb_multi; glitch ports exist only with DEB_GLITCH_CNT_EN.
interface deb_multi_if import deb_pkg::*; #(
   parameter int N = 2,
   parameter int CNT_W = CNT_W_DEF
) ();
   logic [N-1:0] in;
   logic [CNT_W-1:0] thresh;
   logic [N-1:0] out;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
`ifdef DEB_GLITCH_CNT_EN
   logic glitch_clr;
   logic [N*GLITCH_W-1:0] glitch_cnt;
   modport master (output in, thresh, glitch_clr, input out, rise, fall, glitch_cnt);
   modport slave (input in, thresh, glitch_clr, output out, rise, fall, glitch_cnt);
`else
   modport master (output in, thresh, input out, rise, fall);
   modport slave (input in, thresh, output out, rise, fall);
`endif
endinterface

// File: rtl/deb_ch.sv
// deb_ch: one debounce channel (synchroniser, saturating stability counter, strobes, glitch counter under DEB_GLITCH_CNT_EN).
module deb_ch import deb_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic [CNT_W-1:0] thresh,
`ifdef DEB_GLITCH_CNT_EN
   input  logic glitch_clr,
   output glitch_t glitch_cnt,
`endif
   output logic out,
   output logic rise,
   output logic fall
);
   logic sync0, sync1, prev, changed, upd;
   logic [CNT_W-1:0] cnt;
   assign changed = sync1 ^ prev;
   assign upd = !changed && (cnt >= thresh) && (prev != out);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync0 <= RST_VAL;
         sync1 <= RST_VAL;
         prev  <= RST_VAL;
         out   <= RST_VAL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync0 <= in;
         sync1 <= sync0;
         prev  <= sync1;
         cnt   <= changed ? '0 : (&cnt ? cnt : cnt + 1'b1);
         out   <= upd ? prev : out;
         rise  <= upd && prev;
         fall  <= upd && !prev;
      end
`ifdef DEB_GLITCH_CNT_EN
   // a bounce while a new level is pending aborts that transition
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         glitch_cnt <= '0;
      else
         glitch_cnt <= glitch_clr ? '0 :
                       (changed && prev != out && glitch_cnt != GLITCH_MAX) ? glitch_cnt + 1'b1 : glitch_cnt;
`endif
endmodule

// File: rtl/deb_multi.sv
// deb_multi: N-channel debouncer with rise/fall strobes; glitch counters added when DEB_GLITCH_CNT_EN is defined.
module deb_multi import deb_pkg::*; #(
   parameter int N = 2,
   parameter int CNT_W = CNT_W_DEF,
   parameter logic [N-1:0] RST_VAL = {N{1'b0}}
) (
   input logic clk,
   input logic rst_n,
   deb_multi_if.slave bus
);
   for (genvar i = 0; i < N; i++) begin : g_ch
      deb_ch #(.CNT_W(CNT_W), .RST_VAL(RST_VAL[i])) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .in(bus.in[i]),
         .thresh(bus.thresh),
`ifdef DEB_GLITCH_CNT_EN
         .glitch_clr(bus.glitch_clr),
         .glitch_cnt(bus.glitch_cnt[i*GLITCH_W +: GLITCH_W]),
`endif
         .out(bus.out[i]),
         .rise(bus.rise[i]),
         .fall(bus.fall[i])
      );
   end
endmodule

// File: doc/deb_multi.md
Name: deb_multi

Overview:
- N-channel parametrised debouncer for keyboard/PS2-side inputs (PS2 clk/data lines, buttons), with per-channel 2-FF synchroniser, stability counter and runtime-programmable threshold.
- Adds per-channel registered rise/fall strobes and a configurable reset level.
- Sits between the pad inputs and the PS2 receiver / control FSMs; all outputs are synchronous to clk.

Parameters:
- N, 2, number of independent channels (>=1)
- CNT_W, 4, width of the stability counter and the threshold input (>=1)
- RST_VAL, {N{1'b0}}, N-bit per-channel reset level for the synchroniser flops, sample flop and out

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in  in  N  raw asynchronous inputs, one bit per channel
- thresh  in  CNT_W  required count of stable cycles, shared by all channels, sampled every cycle
- out  out  N  debounced level per channel
- rise  out  N  one-cycle strobe, high in the cycle out[i] goes 0->1
- fall  out  N  one-cycle strobe, high in the cycle out[i] goes 1->0

Behaviour:
- Per channel i, registers: sync0, sync1 (synchroniser), prev (sample of sync1), cnt[CNT_W], out, rise, fall.
- Reset (async, rst_n low): sync0 = sync1 = prev = out = RST_VAL[i]; cnt = 0; rise = fall = 0. No strobe is generated on reset release.
- Every edge: sync0 <= in; sync1 <= sync0; prev <= sync1.
- changed = sync1 ^ prev.
  - changed -> cnt <= 0.
  - else -> cnt <= cnt + 1, saturating at all-ones (never wraps).
- stable = !changed && (cnt >= thresh).
  - stable && prev != out -> out <= prev; rise <= prev; fall <= !prev.
  - otherwise out holds; rise <= 0; fall <= 0.
- Latency: a clean input step that is held reaches out exactly thresh+4 clk edges after the first edge that samples it. Example: thresh = 3 gives 7 edges.
- A pulse on in shorter than thresh+1 cycles (at sync1) never reaches out.
- Strobes are registered and coincide with the cycle in which out has its new value. At most one of rise/fall is high per channel.
- thresh = 0: out follows prev one edge later whenever changed is low (minimum filtering, latency 4).
- thresh changed at runtime takes effect on the next compare.
  - Lowering thresh below the current cnt may update out on the next edge.
  - cnt is not cleared when thresh changes.
- Saturated cnt (all-ones) with thresh = all-ones counts as stable.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset asserted mid-count: all state returns to reset values immediately; pending transitions are discarded.

Optional Feature:
- Macro DEB_GLITCH_CNT_EN.
- Defined:
  - Adds ports glitch_clr (in, 1) and glitch_cnt (out, N*8, channel i at bits [8i+7:8i]).
  - glitch_cnt[i] increments, saturating at 255, on each cycle where changed is high and prev != out. This counts a bounce that aborts a pending transition.
  - glitch_clr high clears all glitch counters on the next edge and has priority over increment.
  - Reset value is 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package deb_pkg: GLITCH_W = 8 and GLITCH_MAX = 8'hFF constants; default CNT_W.
- Sub-module deb_ch: one channel containing the synchroniser, counter, out and strobes, plus the optional glitch counter.
- Top level: a generate loop instantiating deb_ch N times and slicing RST_VAL and glitch_cnt per channel.

Test Plan:
- Reset with RST_VAL = 2'b10, in = 2'b10, release rst_n -> out = 2'b10 and rise = fall = 0 on every cycle after release.
- N=2, thresh=3, in[0] steps 0->1 and holds -> out[0] rises exactly 7 edges later, rise[0] high for 1 cycle, out[1] unchanged.
- thresh=3, in[0] high for 3 cycles then low -> out[0] stays 0, no strobe. With DEB_GLITCH_CNT_EN defined -> glitch_cnt[0] = 1.
- Both channels toggle on the same edge (ch0 0->1, ch1 1->0) -> rise[0] and fall[1] assert in the same cycle.
- thresh=15, CNT_W=4, hold in for 100 cycles -> cnt saturates at 15 and out stays stable without wrap. Then set thresh=0 and toggle in -> out follows 4 edges later.
- Assert rst_n mid-count (cnt=2, thresh=5) -> out, cnt and strobes return to reset values immediately, with no strobe after release.
